// File: rtl/mc_control.sv
// ---------------------------------------------------------------------------
// mc_control -- main control unit of a multi-cycle MIPS-style datapath.
//
// A Moore FSM. The outputs are decoded from the state register alone, so there
// is no combinational path from opcode to any output. The reset input also
// forces every control output to 0 while it is high, because the FETCH state
// would otherwise assert pcwrite, memread and irwrite during reset.
//
// Optional feature: define MC_CONTROL_ORI_EN to enable the ori instruction
// (ORIEX/ORIWB states). If it is not defined, opcode 001101 is an illegal
// opcode and codes 10-11 behave like every other unused code.
//
// Ports:
//   clk          in   clock; all state updates occur on its rising edge
//   reset        in   asynchronous, active-high reset
//   opcode[5:0]  in   instruction[31:26]; sampled only in DECODE and MEMADR
//   pcwrite, pcwritecond, iord, memread, memwrite, memtoreg, irwrite,
//   alusrca, regwrite, regdst
//                out  datapath enables and mux selects
//   alusrcb[1:0] out  ALU B select (00 B, 01 4, 10 imm, 11 imm<<2)
//   pcsource[1:0] out PC select (00 ALU, 01 ALUOut, 10 jump target)
//   aluop1/aluop0 out ALU control (00 add, 01 sub, 10 decoded)
//   state[3:0]   out  current state code (debug)
// ---------------------------------------------------------------------------
module mc_control (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opcode,
    output logic       pcwrite,
    output logic       pcwritecond,
    output logic       iord,
    output logic       memread,
    output logic       memwrite,
    output logic       memtoreg,
    output logic       irwrite,
    output logic       alusrca,
    output logic       regwrite,
    output logic       regdst,
    output logic [1:0] alusrcb,
    output logic [1:0] pcsource,
    output logic       aluop1,
    output logic       aluop0,
    output logic [3:0] state
);

    localparam logic [5:0] OP_LW  = 6'b100011;
    localparam logic [5:0] OP_SW  = 6'b101011;
    localparam logic [5:0] OP_RT  = 6'b000000;
    localparam logic [5:0] OP_BEQ = 6'b000100;
    localparam logic [5:0] OP_J   = 6'b000010;
`ifdef MC_CONTROL_ORI_EN
    localparam logic [5:0] OP_ORI = 6'b001101;
`endif

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_RWB    = 4'd7,
        S_BRANCH = 4'd8,
        S_JUMP   = 4'd9,
        S_ORIEX  = 4'd10,
        S_ORIWB  = 4'd11
    } state_t;

    state_t     r_state;
    logic [1:0] w_aluop;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_FETCH;
        end else begin
            case (r_state)
                S_FETCH:  r_state <= S_DECODE;
                S_DECODE: begin
                    case (opcode)
                        OP_LW, OP_SW: r_state <= S_MEMADR;
                        OP_RT:        r_state <= S_EXEC;
                        OP_BEQ:       r_state <= S_BRANCH;
                        OP_J:         r_state <= S_JUMP;
`ifdef MC_CONTROL_ORI_EN
                        OP_ORI:       r_state <= S_ORIEX;
`endif
                        // Illegal opcodes retire as a 2-cycle NOP.
                        default:      r_state <= S_FETCH;
                    endcase
                end
                S_MEMADR: r_state <= (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
                S_MEMRD:  r_state <= S_MEMWB;
                S_MEMWB:  r_state <= S_FETCH;
                S_MEMWR:  r_state <= S_FETCH;
                S_EXEC:   r_state <= S_RWB;
                S_RWB:    r_state <= S_FETCH;
                S_BRANCH: r_state <= S_FETCH;
                S_JUMP:   r_state <= S_FETCH;
`ifdef MC_CONTROL_ORI_EN
                S_ORIEX:  r_state <= S_ORIWB;
                S_ORIWB:  r_state <= S_FETCH;
`endif
                // Unused codes recover to FETCH.
                default:  r_state <= S_FETCH;
            endcase
        end
    end

    // Output decode from the state register only. Reset gating makes the
    // write enables drop immediately when reset aborts an instruction.
    always_comb begin
        pcwrite     = 1'b0;
        pcwritecond = 1'b0;
        iord        = 1'b0;
        memread     = 1'b0;
        memwrite    = 1'b0;
        memtoreg    = 1'b0;
        irwrite     = 1'b0;
        alusrca     = 1'b0;
        regwrite    = 1'b0;
        regdst      = 1'b0;
        alusrcb     = 2'b00;
        pcsource    = 2'b00;
        w_aluop     = 2'b00;
        if (!reset) begin
            case (r_state)
                S_FETCH: begin
                    memread = 1'b1;
                    irwrite = 1'b1;
                    alusrcb = 2'b01;
                    pcwrite = 1'b1;
                end
                S_DECODE: alusrcb = 2'b11;
                S_MEMADR: begin
                    alusrca = 1'b1;
                    alusrcb = 2'b10;
                end
                S_MEMRD: begin
                    memread = 1'b1;
                    iord    = 1'b1;
                end
                S_MEMWB: begin
                    regwrite = 1'b1;
                    memtoreg = 1'b1;
                end
                S_MEMWR: begin
                    memwrite = 1'b1;
                    iord     = 1'b1;
                end
                S_EXEC: begin
                    alusrca = 1'b1;
                    w_aluop = 2'b10;
                end
                S_RWB: begin
                    regwrite = 1'b1;
                    regdst   = 1'b1;
                end
                S_BRANCH: begin
                    alusrca     = 1'b1;
                    w_aluop     = 2'b01;
                    pcwritecond = 1'b1;
                    pcsource    = 2'b01;
                end
                S_JUMP: begin
                    pcwrite  = 1'b1;
                    pcsource = 2'b10;
                end
`ifdef MC_CONTROL_ORI_EN
                S_ORIEX: begin
                    alusrca = 1'b1;
                    alusrcb = 2'b10;
                    w_aluop = 2'b10;
                end
                S_ORIWB: regwrite = 1'b1;
`endif
                default: ;
            endcase
        end
    end

    assign aluop1 = w_aluop[1];
    assign aluop0 = w_aluop[0];
    assign state  = r_state;

endmodule

// File: tb/tb_mc_control.sv
// ---------------------------------------------------------------------------
// tb_mc_control -- self-checking bench for mc_control.
// A behavioural model tracks each instruction as a queue of states still to
// visit; a compare process checks state and all outputs at every falling
// edge. Directed sequences pin the model with literal state traces.
// ---------------------------------------------------------------------------
module tb_mc_control;

    logic       clk;
    logic       reset;
    logic [5:0] opcode;
    logic       pcwrite, pcwritecond, iord, memread, memwrite, memtoreg;
    logic       irwrite, alusrca, regwrite, regdst, aluop1, aluop0;
    logic [1:0] alusrcb, pcsource;
    logic [3:0] state;

    localparam logic [5:0] OP_LW  = 6'b100011;
    localparam logic [5:0] OP_SW  = 6'b101011;
    localparam logic [5:0] OP_RT  = 6'b000000;
    localparam logic [5:0] OP_BEQ = 6'b000100;
    localparam logic [5:0] OP_J   = 6'b000010;
    localparam logic [5:0] OP_ORI = 6'b001101;
    localparam logic [5:0] OP_BAD = 6'b111111;

    mc_control dut (
        .clk(clk), .reset(reset), .opcode(opcode),
        .pcwrite(pcwrite), .pcwritecond(pcwritecond), .iord(iord),
        .memread(memread), .memwrite(memwrite), .memtoreg(memtoreg),
        .irwrite(irwrite), .alusrca(alusrca), .regwrite(regwrite),
        .regdst(regdst), .alusrcb(alusrcb), .pcsource(pcsource),
        .aluop1(aluop1), .aluop0(aluop0), .state(state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Bit map: [15]pcwrite [14]pcwritecond [13]iord [12]memread [11]memwrite
    // [10]memtoreg [9]irwrite [8]alusrca [7]regwrite [6]regdst
    // [5:4]alusrcb [3:2]pcsource [1:0]aluop
    logic [15:0] dut_vec;
    assign dut_vec = {pcwrite, pcwritecond, iord, memread, memwrite, memtoreg,
                      irwrite, alusrca, regwrite, regdst, alusrcb, pcsource,
                      aluop1, aluop0};

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Expected outputs for each state, taken from the state descriptions.
    function automatic logic [15:0] exp_vec(input int s);
        logic pw, pwc, io, mr, mw, mtr, irw, asa, rw, rd;
        logic [1:0] sb, ps, aop;
        {pw, pwc, io, mr, mw, mtr, irw, asa, rw, rd} = '0;
        sb = 2'd0; ps = 2'd0; aop = 2'd0;
        case (s)
            0:  begin mr = 1; irw = 1; sb = 2'd1; pw = 1; end
            1:  sb = 2'd3;
            2:  begin asa = 1; sb = 2'd2; end
            3:  begin mr = 1; io = 1; end
            4:  begin rw = 1; mtr = 1; end
            5:  begin mw = 1; io = 1; end
            6:  begin asa = 1; aop = 2'd2; end
            7:  begin rw = 1; rd = 1; end
            8:  begin asa = 1; aop = 2'd1; pwc = 1; ps = 2'd1; end
            9:  begin pw = 1; ps = 2'd2; end
`ifdef MC_CONTROL_ORI_EN
            10: begin asa = 1; sb = 2'd2; aop = 2'd2; end
            11: rw = 1;
`endif
            default: ;
        endcase
        return {pw, pwc, io, mr, mw, mtr, irw, asa, rw, rd, sb, ps, aop};
    endfunction

    // Reference model: each instruction is a list of states after DECODE.
    int m_state;
    int m_q[$];

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_state = 0;
            m_q.delete();
        end else begin
            if (m_state == 1) begin
                m_q.delete();
                if (opcode == OP_LW || opcode == OP_SW) m_q.push_back(2);
                else if (opcode == OP_RT) begin m_q.push_back(6); m_q.push_back(7); end
                else if (opcode == OP_BEQ) m_q.push_back(8);
                else if (opcode == OP_J) m_q.push_back(9);
`ifdef MC_CONTROL_ORI_EN
                else if (opcode == OP_ORI) begin m_q.push_back(10); m_q.push_back(11); end
`endif
            end else if (m_state == 2) begin
                m_q.delete();
                if (opcode == OP_LW) begin m_q.push_back(3); m_q.push_back(4); end
                else m_q.push_back(5);
            end
            if (m_state == 0) m_state = 1;
            else if (m_q.size() > 0) m_state = m_q.pop_front();
            else m_state = 0;
        end
    end

    bit cmp_en = 1'b0;

    always @(negedge clk) begin
        if (cmp_en) begin
            if (reset) begin
                chk("rst_state", int'(state), 0);
                chk("rst_outs", int'(dut_vec), 0);
            end else begin
                chk("model_state", int'(state), m_state);
                chk("model_outs", int'(dut_vec), int'(exp_vec(m_state)));
            end
        end
    end

    // Directed trace: called just after a falling edge with the DUT in FETCH.
    int          exp_q[$];
    logic [15:0] obs_vec[16];

    task automatic run_seq(input string name, input logic [5:0] op);
        opcode = op;
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i > 0) begin @(negedge clk); #1; end
            chk($sformatf("%s_state[%0d]", name, i), int'(state), exp_q[i]);
            obs_vec[i] = dut_vec;
        end
    endtask

    initial begin
        reset  = 1'b1;
        opcode = OP_BAD;
        cmp_en = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_hold_state", int'(state), 0);
        chk("rst_hold_pcwrite", int'(pcwrite), 0);
        chk("rst_hold_memread", int'(memread), 0);
        reset = 1'b0;
        #1;
        chk("rel_state", int'(state), 0);
        chk("rel_pcwrite", int'(pcwrite), 1);
        chk("rel_memread", int'(memread), 1);
        chk("rel_irwrite", int'(irwrite), 1);
        @(negedge clk); #1;
        chk("rel_first_edge", int'(state), 1);
        @(negedge clk); #1;
        chk("rel_nop_back", int'(state), 0);

        exp_q = '{0, 1, 2, 3, 4, 0};
        run_seq("lw", OP_LW);
        for (int i = 0; i < 6; i++) begin
            chk($sformatf("lw_memtoreg[%0d]", i), int'(obs_vec[i][10]), int'(i == 4));
            chk($sformatf("lw_regwrite[%0d]", i), int'(obs_vec[i][7]), int'(i == 4));
        end

        exp_q = '{0, 1, 6, 7, 0};
        run_seq("rtype", OP_RT);
        chk("rtype_aluop_s6", int'(obs_vec[2][1:0]), 2);
        chk("rtype_regdst_s7", int'(obs_vec[3][6]), 1);

        exp_q = '{0, 1, 8, 0};
        run_seq("beq", OP_BEQ);
        chk("beq_aluop_s8", int'(obs_vec[2][1:0]), 1);
        chk("beq_pcwritecond_s8", int'(obs_vec[2][14]), 1);

        exp_q = '{0, 1, 9, 0};
        run_seq("j", OP_J);
        chk("j_pcsource_s9", int'(obs_vec[2][3:2]), 2);

`ifdef MC_CONTROL_ORI_EN
        exp_q = '{0, 1, 10, 11, 0};
`else
        exp_q = '{0, 1, 0};
`endif
        run_seq("ori", OP_ORI);

        exp_q = '{0, 1, 0};
        run_seq("illegal", OP_BAD);

        exp_q = '{0, 1, 2, 5};
        run_seq("sw", OP_SW);
        chk("sw_memwrite_s5", int'(memwrite), 1);
        #2 reset = 1'b1;
        #1;
        chk("abort_memwrite", int'(memwrite), 0);
        chk("abort_state", int'(state), 0);
        chk("abort_regwrite", int'(regwrite), 0);
        chk("abort_pcwrite", int'(pcwrite), 0);
        @(negedge clk); #1;
        reset = 1'b0;
        #1;
        chk("abort_release_state", int'(state), 0);

        for (int c = 0; c < 3000; c++) begin
            @(negedge clk); #1;
            case ($urandom_range(0, 7))
                0: opcode = OP_LW;
                1: opcode = OP_SW;
                2: opcode = OP_RT;
                3: opcode = OP_BEQ;
                4: opcode = OP_J;
                5: opcode = OP_ORI;
                default: opcode = 6'($urandom);
            endcase
            if ($urandom_range(0, 99) == 0) begin
                #($urandom_range(1, 2));
                reset = 1'b1;
                #1;
                chk("rand_rst_state", int'(state), 0);
                chk("rand_rst_outs", int'(dut_vec), 0);
                @(negedge clk); #1;
                reset = 1'b0;
            end
        end

        repeat (2) @(negedge clk);
        cmp_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
